tiq_therm_encoder: RTL

Parametrised, pipelined thermometer-to-binary encoder for the TIQ ADC comparator bank. It synchronises the asynchronous comparator outputs and applies 3-input majority bubble correction. It then encodes the corrected vector to an N-bit code and optionally accumulates 2^AVG_LOG2 consecutive valid codes into an oversampled sum. It sits between the comparator array and the digital readout, replacing the fixed 7-comparator, 3-bit combinational encoder.

---
 rtl/tiq_therm_encoder.sv | 107 ++++++++++
 1 files changed

// File: rtl/tiq_therm_encoder.sv
// Pipelined thermometer-to-binary encoder for the TIQ comparator bank:
// 2-flop sync, majority bubble correction, popcount encode, optional group sum.
module tiq_therm_encoder #(
  parameter int N_BITS   = 3,
  parameter int AVG_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [(2**N_BITS)-2:0]     therm_in,
  input  logic                       clr_err,
  output logic [N_BITS-1:0]          code,
  output logic                       code_valid,
  output logic [N_BITS+AVG_LOG2-1:0] avg_out,
  output logic                       avg_valid,
  output logic                       bubble_err,
  output logic [7:0]                 bubble_cnt
);

  localparam int T  = (2**N_BITS) - 1;
  localparam int AW = N_BITS + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((2**AVG_LOG2) - 1);

  logic [T-1:0]    s1, s2, corr_q, corr_d;
  logic            v1, v2, v3;
  logic            bub_q, bub_d;
  logic [T+1:0]    se;
  logic [N_BITS-1:0] pc;
  logic [AW-1:0]   acc, acc_sum;
  logic [CW-1:0]   cnt;

  // Pad with a 1 below the lowest comparator and a 0 above the highest.
  assign se    = {1'b0, s2, 1'b1};
  assign bub_d = |(~s2[T-2:0] & s2[T-1:1]);

  always_comb begin
    corr_d = '0;
    for (int i = 0; i < T; i++) begin
      corr_d[i] = (se[i] & se[i+1]) | (se[i] & se[i+2]) | (se[i+1] & se[i+2]);
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < T; i++) begin
      pc = pc + N_BITS'(corr_q[i]);
    end
  end

  assign acc_sum = acc + AW'(code);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      corr_q     <= '0;
      bub_q      <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      bubble_err <= 1'b0;
      bubble_cnt <= '0;
      acc        <= '0;
      cnt        <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
    end else begin
      s1     <= therm_in;
      s2     <= s1;
      v1     <= en;
      v2     <= v1;
      v3     <= v2;
      corr_q <= corr_d;
      bub_q  <= bub_d;

      code_valid <= v3;
      if (v3) code <= pc;

      // A bubble arriving with clr_err restarts the count at one.
      if (v3 && bub_q) begin
        bubble_err <= 1'b1;
        if (clr_err)                 bubble_cnt <= 8'd1;
        else if (bubble_cnt != 8'hFF) bubble_cnt <= bubble_cnt + 8'd1;
      end else if (clr_err) begin
        bubble_err <= 1'b0;
        bubble_cnt <= '0;
      end

      avg_valid <= 1'b0;
      if (code_valid) begin
        if (cnt == CNT_LAST) begin
          avg_out   <= acc_sum;
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
